// File: rtl/subpel_row_sched_if.sv
// Bundle between the sub-pel row scheduler and its environment: job config,
// reference pixel stream, FIR bank window/results and framed output stream.
interface subpel_row_sched_if;
  logic        start;
  logic [1:0]  cfg_frac;
  logic [3:0]  cfg_w;
  logic [3:0]  cfg_h;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] fir_window;
  logic [7:0]  fir_a_px;
  logic [7:0]  fir_b_px;
  logic [7:0]  fir_c_px;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_last_col;
  logic        out_last;
  logic        busy;

  modport master (
    output start, cfg_frac, cfg_w, cfg_h, in_pixel, in_valid,
    output fir_a_px, fir_b_px, fir_c_px,
    input  in_ready, fir_window, out_pixel, out_valid, out_last_col, out_last, busy
  );

  modport slave (
    input  start, cfg_frac, cfg_w, cfg_h, in_pixel, in_valid,
    input  fir_a_px, fir_b_px, fir_c_px,
    output in_ready, fir_window, out_pixel, out_valid, out_last_col, out_last, busy
  );
endinterface

// File: rtl/subpel_row_sched.sv
// Row scheduler for HEVC horizontal sub-pel interpolation: primes and slides the
// 8-pixel FIR window row by row and frames one filtered pixel per window.
module subpel_row_sched (
  input  logic              clock,
  input  logic              reset,
  subpel_row_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] PRIME_LAST = 4'd6;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  frac_r;
  logic [3:0]  w_r;
  logic [3:0]  h_r;
  logic [3:0]  col_r;
  logic [3:0]  col_s;
  logic [3:0]  row_r;
  logic [3:0]  row_s;
  logic        load_cfg_s;
  logic [63:0] win_r;
  logic [7:0]  int_px_r;
  logic        v1_r;
  logic        v2_r;
  logic        lc1_r;
  logic        lc2_r;
  logic        l1_r;
  logic        l2_r;
  logic        accept_s;
  logic        run_acc_s;
  logic        row_end_s;
  logic        blk_end_s;
  logic [7:0]  sel_px_s;

  assign bus.in_ready = (state_r == ST_PRIME) || (state_r == ST_RUN);
  assign bus.busy     = (state_r != ST_IDLE);
  assign accept_s     = bus.in_valid & bus.in_ready;
  assign run_acc_s    = accept_s && (state_r == ST_RUN);
  assign row_end_s    = (col_r == w_r);
  assign blk_end_s    = row_end_s && (row_r == h_r);

  // Next-state, column/row counter and config-load decode.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    row_s      = row_r;
    load_cfg_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_cfg_s = 1'b1;
          col_s      = 4'd0;
          row_s      = 4'd0;
          state_s    = ST_PRIME;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (accept_s && (col_r == PRIME_LAST)) begin
          col_s   = 4'd0;
          state_s = ST_RUN;
        end else if (accept_s) begin
          col_s = col_r + 4'd1;
        end else begin
          col_s = col_r;
        end
      end
      ST_RUN: begin
        if (accept_s && blk_end_s) begin
          col_s   = 4'd0;
          state_s = ST_DRAIN;
        end else if (accept_s && row_end_s) begin
          col_s   = 4'd0;
          row_s   = row_r + 4'd1;
          state_s = ST_PRIME;
        end else if (accept_s) begin
          col_s = col_r + 4'd1;
        end else begin
          col_s = col_r;
        end
      end
      ST_DRAIN: begin
        if (v2_r && l2_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and latched job configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      col_r   <= 4'd0;
      row_r   <= 4'd0;
      frac_r  <= 2'd0;
      w_r     <= 4'd0;
      h_r     <= 4'd0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      if (load_cfg_s) begin
        frac_r <= bus.cfg_frac;
        w_r    <= bus.cfg_w;
        h_r    <= bus.cfg_h;
      end
    end
  end

  // Sliding window: newest pixel enters byte 7; never cleared between rows
  // because the 8 accepts preceding each row's first output refill it.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_r <= 64'd0;
    end else if (accept_s) begin
      win_r <= {bus.in_pixel, win_r[63:8]};
    end
  end

  // Two-stage valid pipeline with framing tags; the integer-phase pixel is
  // captured on the same edge the FIR bank samples the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      lc1_r    <= 1'b0;
      lc2_r    <= 1'b0;
      l1_r     <= 1'b0;
      l2_r     <= 1'b0;
      int_px_r <= 8'd0;
    end else begin
      v1_r     <= run_acc_s;
      lc1_r    <= run_acc_s && row_end_s;
      l1_r     <= run_acc_s && blk_end_s;
      v2_r     <= v1_r;
      lc2_r    <= lc1_r;
      l2_r     <= l1_r;
      int_px_r <= win_r[31:24];
    end
  end

  // Phase select between integer tap and the three FIR results.
  always_comb begin
    sel_px_s = int_px_r;
    case (frac_r)
      2'd0:    sel_px_s = int_px_r;
      2'd1:    sel_px_s = bus.fir_a_px;
      2'd2:    sel_px_s = bus.fir_b_px;
      2'd3:    sel_px_s = bus.fir_c_px;
      default: sel_px_s = int_px_r;
    endcase
  end

  // FIR_C has 7 taps at -2..+4, so its window is advanced by one byte.
  assign bus.fir_window   = (frac_r == 2'd3) ? {8'h00, win_r[63:8]} : win_r;
  assign bus.out_valid    = v2_r;
  assign bus.out_last_col = lc2_r;
  assign bus.out_last     = l2_r;
  assign bus.out_pixel    = v2_r ? sel_px_s : 8'd0;

endmodule
